data_mem_access_unit: RTL and testbench



---
 rtl/data_mem_access_unit.sv | 131 +++++++++++++
 tb/tb_data_mem_access_unit.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/data_mem_access_unit.sv
// data_mem_access_unit: MEM-stage load/store front end for a word-addressed byte-enabled RAM port,
// splitting misaligned accesses into two consecutive word accesses.
module data_mem_access_unit #(
    parameter int WORD_AW  = 12,
    parameter bit SPLIT_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_type,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [29:0] ram_addra,
    output logic [3:0]  ram_wea,
    output logic [31:0] ram_dina,
    input  logic [31:0] ram_douta
);
    typedef enum logic {IDLE, SPLIT} state_t;

    state_t      state_q, state_d;
    logic        resp_valid_q, resp_valid_d;
    logic        resp_err_q, resp_err_d;
    logic        resp_split_q, resp_split_d;
    logic        we_q, we_d;
    logic [1:0]  off_q, off_d;
    logic [2:0]  type_q, type_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] lo_q, lo_d;
    logic [29:0] wa_q, wa_d;

    logic        sp, accept, illegal, mis, err;
    logic [1:0]  off, s_off;
    logic [2:0]  s_type;
    logic [29:0] wa, wb;
    logic [31:0] s_wdata, comb_word, ext_word;
    logic [3:0]  bm;
    logic [7:0]  be8;
    logic [63:0] d64;
    logic [5:0]  sh_lo, sh_hi;

    assign sp        = (state_q == SPLIT);
    assign req_ready = !sp;
    assign accept    = req_valid && req_ready;
    assign off       = req_addr[1:0];
    assign wa        = req_addr[31:2];
    assign wb        = wa + 30'd1;
    assign illegal   = (req_type == 3'b011) || (req_type[2:1] == 2'b11) || (req_we && req_type[2]);
    assign mis       = (req_type[1:0] == 2'b01 && off == 2'd3) || (req_type[1:0] == 2'b10 && off != 2'd0);
    assign err       = illegal || (wa[29:WORD_AW] != '0) || (mis && (wb[29:WORD_AW] != '0)) || (mis && !SPLIT_EN);

    // Lane mask and data are built 64 bits wide: the low half is word A, the high half word B.
    assign s_type  = sp ? type_q : req_type;
    assign s_off   = sp ? off_q : off;
    assign s_wdata = sp ? wdata_q : req_wdata;
    assign bm      = s_type[1] ? 4'hF : s_type[0] ? 4'h3 : 4'h1;
    assign be8     = {4'h0, bm} << s_off;
    assign d64     = {32'h0, s_wdata} << {s_off, 3'b000};

    assign ram_addra = sp ? wa_q + 30'd1 : accept ? wa : 30'd0;
    assign ram_dina  = sp ? d64[63:32] : d64[31:0];
    assign ram_wea   = !rst_n ? 4'h0 : sp ? (we_q ? be8[7:4] : 4'h0) : (accept && req_we && !err) ? be8[3:0] : 4'h0;

    assign sh_lo      = {1'b0, off_q, 3'b000};
    assign sh_hi      = 6'd32 - sh_lo;
    assign comb_word  = resp_split_q ? ((ram_douta << sh_hi) | (lo_q >> sh_lo)) : (ram_douta >> sh_lo);
    assign ext_word   = type_q[1] ? comb_word
                      : type_q[0] ? {type_q[2] ? 16'h0 : {16{comb_word[15]}}, comb_word[15:0]}
                      : {type_q[2] ? 24'h0 : {24{comb_word[7]}}, comb_word[7:0]};
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = (resp_valid_q && !resp_err_q && !we_q) ? ext_word : 32'h0;

    always_comb begin
        state_d      = state_q;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_split_d = 1'b0;
        we_d         = we_q;
        off_d        = off_q;
        type_d       = type_q;
        wdata_d      = wdata_q;
        lo_d         = lo_q;
        wa_d         = wa_q;
        if (sp) begin
            state_d      = IDLE;
            resp_valid_d = 1'b1;
            resp_split_d = 1'b1;
            lo_d         = ram_douta;
        end else if (accept) begin
            state_d      = (!err && mis) ? SPLIT : IDLE;
            resp_valid_d = err || !mis;
            resp_err_d   = err;
            we_d         = req_we;
            off_d        = off;
            type_d       = req_type;
            wdata_d      = req_wdata;
            wa_d         = wa;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_split_q <= 1'b0;
            we_q         <= 1'b0;
            off_q        <= 2'd0;
            type_q       <= 3'd0;
            wdata_q      <= 32'h0;
            lo_q         <= 32'h0;
            wa_q         <= 30'd0;
        end else begin
            state_q      <= state_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_split_q <= resp_split_d;
            we_q         <= we_d;
            off_q        <= off_d;
            type_q       <= type_d;
            wdata_q      <= wdata_d;
            lo_q         <= lo_d;
            wa_q         <= wa_d;
        end
    end
endmodule

// File: tb/tb_data_mem_access_unit.sv
// tb_data_mem_access_unit: directed stimulus with a response scoreboard and a behavioural RAM.
module tb_data_mem_access_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_type = 3'd0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [29:0] ram_addra;
    logic [3:0]  ram_wea;
    logic [31:0] ram_dina;
    logic [31:0] ram_douta = 32'h0;

    typedef struct {logic err; logic [31:0] rd; int cyc;} exp_t;
    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    logic clr = 1'b1;
    logic [31:0] mem [0:4095];

    data_mem_access_unit #(.WORD_AW(12), .SPLIT_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_type(req_type), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .ram_addra(ram_addra), .ram_wea(ram_wea), .ram_dina(ram_dina), .ram_douta(ram_douta)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < 4096; i++) mem[i] <= 32'h0;
        end else begin
            for (int i = 0; i < 4; i++)
                if (ram_wea[i]) mem[ram_addra[11:0]][8*i +: 8] <= ram_dina[8*i +: 8];
        end
        ram_douta <= mem[ram_addra[11:0]];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (resp_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp: got resp_valid at cycle %0d expected none", cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("resp_cycle", cyc, e.cyc);
                chk("resp_err", {31'h0, resp_err}, {31'h0, e.err});
                chk("resp_rdata", resp_rdata, e.rd);
            end
        end
    end

    task automatic send(input logic we, input logic [2:0] t, input logic [31:0] a, input logic [31:0] w,
                        input logic e, input logic [31:0] rd, input int lat);
        req_valid = 1'b1;
        req_we    = we;
        req_type  = t;
        req_addr  = a;
        req_wdata = w;
        exp_q.push_back('{e, rd, cyc + lat});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        chk("rst_resp_err", {31'h0, resp_err}, 32'h0);
        chk("rst_req_ready", {31'h0, req_ready}, 32'h1);
        chk("rst_wea", {28'h0, ram_wea}, 32'h0);
        chk("rst_addra", {2'b0, ram_addra}, 32'h0);
        clr = 1'b0;
        rst_n = 1'b1;
        step();

        send(1, 3'b010, 32'h8, 32'h11223344, 0, 32'h0, 1);
        @(negedge clk);
        chk("sw_wea", {28'h0, ram_wea}, 32'hF);
        chk("sw_addra", {2'b0, ram_addra}, 32'h2);
        chk("sw_dina", ram_dina, 32'h11223344);
        step();
        send(0, 3'b010, 32'h8, 32'h0, 0, 32'h11223344, 1);
        step();

        send(1, 3'b000, 32'h3, 32'h80, 0, 32'h0, 1);
        @(negedge clk);
        chk("sb_wea", {28'h0, ram_wea}, 32'h8);
        chk("sb_dina", ram_dina, 32'h80000000);
        step();
        send(0, 3'b000, 32'h3, 32'h0, 0, 32'hFFFFFF80, 1);
        step();
        send(0, 3'b100, 32'h3, 32'h0, 0, 32'h00000080, 1);
        step();
        send(0, 3'b001, 32'h2, 32'h0, 0, 32'hFFFF8000, 1);
        step();
        send(0, 3'b101, 32'h2, 32'h0, 0, 32'h00008000, 1);
        step();

        send(1, 3'b010, 32'h5, 32'h11223344, 0, 32'h0, 2);
        @(negedge clk);
        chk("ssplit_a_addra", {2'b0, ram_addra}, 32'h1);
        chk("ssplit_a_wea", {28'h0, ram_wea}, 32'hE);
        chk("ssplit_a_dina", ram_dina, 32'h22334400);
        step();
        @(negedge clk);
        chk("ssplit_b_addra", {2'b0, ram_addra}, 32'h2);
        chk("ssplit_b_wea", {28'h0, ram_wea}, 32'h1);
        chk("ssplit_b_dina", ram_dina, 32'h00000011);
        chk("ssplit_ready", {31'h0, req_ready}, 32'h0);
        step();
        send(0, 3'b010, 32'h5, 32'h0, 0, 32'h11223344, 2);
        step();
        step();
        send(0, 3'b001, 32'h6, 32'h0, 0, 32'h00002233, 1);
        step();

        send(0, 3'b010, 32'h3FFD, 32'h0, 1, 32'h0, 1);
        step();
        send(1, 3'b010, 32'h3FFD, 32'hDEADBEEF, 1, 32'h0, 1);
        @(negedge clk);
        chk("err_last_wea", {28'h0, ram_wea}, 32'h0);
        step();
        send(1, 3'b010, 32'h10000, 32'hDEADBEEF, 1, 32'h0, 1);
        @(negedge clk);
        chk("err_range_wea", {28'h0, ram_wea}, 32'h0);
        step();
        send(0, 3'b011, 32'h0, 32'h0, 1, 32'h0, 1);
        step();
        send(1, 3'b100, 32'h0, 32'hFF, 1, 32'h0, 1);
        @(negedge clk);
        chk("err_sbu_wea", {28'h0, ram_wea}, 32'h0);
        step();
        send(0, 3'b010, 32'h3FFC, 32'h0, 0, 32'h0, 1);
        step();

        send(0, 3'b010, 32'h0, 32'h0, 0, 32'h80000000, 1);
        step();
        send(0, 3'b010, 32'h4, 32'h0, 0, 32'h22334400, 1);
        step();
        send(0, 3'b010, 32'h8, 32'h0, 0, 32'h11223311, 1);
        step();
        send(0, 3'b010, 32'hC, 32'h0, 0, 32'h00000000, 1);
        step();
        step();

        req_valid = 1'b1;
        req_we    = 1'b1;
        req_type  = 3'b001;
        req_addr  = 32'h7;
        req_wdata = 32'h0000BEEF;
        step();
        chk("abort_ready_split", {31'h0, req_ready}, 32'h0);
        rst_n = 1'b0;
        #1;
        chk("abort_wea", {28'h0, ram_wea}, 32'h0);
        chk("abort_ready_idle", {31'h0, req_ready}, 32'h1);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        step();
        send(0, 3'b100, 32'h7, 32'h0, 0, 32'h000000EF, 1);
        step();
        send(0, 3'b100, 32'h8, 32'h0, 0, 32'h00000011, 1);
        step();
        send(0, 3'b010, 32'h4, 32'h0, 0, 32'hEF334400, 1);
        step();

        repeat (3) step();
        chk("queue_empty", exp_q.size(), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
